led_feedback: RTL and testbench

- Downstream consumer of the code breaker's `LED_Proc` request.
- On each request it latches the code maker's and code breaker's 12-bit codes (four 3-bit letters each) and scores the guess Mastermind-style: exact matches and misplaced matches.
- It then drives per-position feedback LEDs for a fixed display window and signals completion.
- It runs sequentially, one position per cycle, so scoring is deterministic and easy to verify.

---
 rtl/led_feedback.sv | 151 +++++++++++++++
 tb/tb_led_feedback.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_feedback.sv
// Mastermind-style scorer: latches both codes on an LED_Proc rising edge,
// scores exact then misplaced matches one position per cycle, shows LEDs.
module led_feedback #(
    parameter int DISPLAY_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        LED_Proc,
    input  logic [11:0] codemaker_code,
    input  logic [11:0] codebreaker_code,
    output logic [3:0]  led_exact,
    output logic [3:0]  led_partial,
    output logic [2:0]  exact_count,
    output logic [2:0]  partial_count,
    output logic        all_match,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE, EXACT, PARTIAL, SHOW, DONE
    } state_t;

    localparam logic [7:0] DispLast = 8'(DISPLAY_CYCLES - 1);

    state_t      state_q;
    logic        led_proc_q;
    logic [11:0] maker_q;
    logic [11:0] breaker_q;
    logic [3:0]  exact_q;
    logic [3:0]  partial_q;
    logic [3:0]  consumed_q;
    logic [2:0]  exact_cnt_q;
    logic [2:0]  partial_cnt_q;
    logic [1:0]  pos_q;
    logic [7:0]  disp_q;

    logic        start;
    logic [2:0]  mk_sym;
    logic [2:0]  bk_sym;
    logic        exact_hit_d;
    logic        part_hit_d;
    logic [1:0]  part_j_d;

    function automatic logic [2:0] letter(
        input logic [11:0] code,
        input logic [1:0]  k
    );
        logic [2:0] s;
        unique case (k)
            2'd0: s = code[2:0];
            2'd1: s = code[5:3];
            2'd2: s = code[8:6];
            default: s = code[11:9];
        endcase
        return s;
    endfunction

    assign start  = LED_Proc & ~led_proc_q & (state_q == IDLE);
    assign mk_sym = letter(maker_q, pos_q);
    assign bk_sym = letter(breaker_q, pos_q);

    assign exact_hit_d = (mk_sym == bk_sym) && (bk_sym != 3'd0);

    // First free maker slot, searched 3 down to 0, matching breaker letter pos_q.
    always_comb begin
        logic [1:0] jj;
        part_hit_d = 1'b0;
        part_j_d   = 2'd0;
        jj         = 2'd0;
        if (!exact_q[pos_q] && bk_sym != 3'd0) begin
            for (int k = 0; k < 4; k++) begin
                jj = 2'(3 - k);
                if (!part_hit_d && !exact_q[jj] && !consumed_q[jj]
                    && letter(maker_q, jj) == bk_sym) begin
                    part_hit_d = 1'b1;
                    part_j_d   = jj;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            led_proc_q    <= 1'b1;
            maker_q       <= '0;
            breaker_q     <= '0;
            exact_q       <= '0;
            partial_q     <= '0;
            consumed_q    <= '0;
            exact_cnt_q   <= '0;
            partial_cnt_q <= '0;
            pos_q         <= '0;
            disp_q        <= '0;
        end else begin
            led_proc_q <= LED_Proc;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        maker_q       <= codemaker_code;
                        breaker_q     <= codebreaker_code;
                        exact_q       <= '0;
                        partial_q     <= '0;
                        consumed_q    <= '0;
                        exact_cnt_q   <= '0;
                        partial_cnt_q <= '0;
                        pos_q         <= 2'd3;
                        state_q       <= EXACT;
                    end
                end
                EXACT: begin
                    if (exact_hit_d) begin
                        exact_q[pos_q] <= 1'b1;
                        exact_cnt_q    <= exact_cnt_q + 3'd1;
                    end
                    pos_q <= pos_q - 2'd1;
                    if (pos_q == 2'd0) state_q <= PARTIAL;
                end
                PARTIAL: begin
                    if (part_hit_d) begin
                        partial_q[pos_q]     <= 1'b1;
                        consumed_q[part_j_d] <= 1'b1;
                        partial_cnt_q        <= partial_cnt_q + 3'd1;
                    end
                    pos_q <= pos_q - 2'd1;
                    if (pos_q == 2'd0) begin
                        disp_q  <= '0;
                        state_q <= SHOW;
                    end
                end
                SHOW: begin
                    disp_q <= disp_q + 8'd1;
                    if (disp_q == DispLast) state_q <= DONE;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign led_exact     = (state_q == SHOW) ? exact_q : 4'd0;
    assign led_partial   = (state_q == SHOW) ? partial_q : 4'd0;
    assign exact_count   = exact_cnt_q;
    assign partial_count = partial_cnt_q;
    assign all_match     = (exact_cnt_q == 3'd4);
    assign busy          = (state_q == EXACT) || (state_q == PARTIAL)
                           || (state_q == SHOW);
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_led_feedback.sv
// Bench for led_feedback: vector table and random runs through a
// scoreboard queue, plus held-request and mid-run reset sequences.
module tb_led_feedback;

    localparam int DC = 4;

    typedef struct {
        logic [3:0] le;
        logic [3:0] lp;
        logic [2:0] ec;
        logic [2:0] pc;
    } exp_t;

    typedef struct {
        logic [11:0] m;
        logic [11:0] b;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        LED_Proc;
    logic [11:0] cm;
    logic [11:0] cb;
    logic [3:0]  led_exact;
    logic [3:0]  led_partial;
    logic [2:0]  exact_count;
    logic [2:0]  partial_count;
    logic        all_match;
    logic        busy;
    logic        done;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    led_feedback #(.DISPLAY_CYCLES(DC)) dut (
        .clk(clk),
        .reset(reset),
        .LED_Proc(LED_Proc),
        .codemaker_code(cm),
        .codebreaker_code(cb),
        .led_exact(led_exact),
        .led_partial(led_partial),
        .exact_count(exact_count),
        .partial_count(partial_count),
        .all_match(all_match),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    // Symbol-count formulation of Mastermind scoring.
    function automatic exp_t model(input logic [11:0] m, input logic [11:0] b);
        exp_t r;
        int   avail[8];
        logic [2:0] ms;
        logic [2:0] bs;
        r.le = '0; r.lp = '0; r.ec = '0; r.pc = '0;
        for (int s = 0; s < 8; s++) avail[s] = 0;
        for (int k = 0; k < 4; k++) begin
            ms = m[3*k +: 3];
            bs = b[3*k +: 3];
            if (ms == bs && ms != 3'd0) begin
                r.le[k] = 1'b1;
                r.ec = r.ec + 3'd1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            ms = m[3*k +: 3];
            if (!r.le[k] && ms != 3'd0) avail[ms]++;
        end
        for (int k = 3; k >= 0; k--) begin
            bs = b[3*k +: 3];
            if (!r.le[k] && bs != 3'd0 && avail[bs] > 0) begin
                avail[bs]--;
                r.lp[k] = 1'b1;
                r.pc = r.pc + 3'd1;
            end
        end
        return r;
    endfunction

    task automatic run_case(input logic [11:0] m, input logic [11:0] b,
                            input exp_t e, input string tag);
        int         n;
        bit         got;
        logic [3:0] acc_e;
        logic [3:0] acc_p;
        exp_t       x;
        @(negedge clk);
        cm = m;
        cb = b;
        LED_Proc = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cm = 12'($urandom);
        cb = 12'($urandom);
        n = 0; got = 1'b0; acc_e = '0; acc_p = '0;
        while (n < 60 && !got) begin
            @(negedge clk);
            if (n == 2) LED_Proc = 1'b0;
            if (done) got = 1'b1;
            else begin
                acc_e |= led_exact;
                acc_p |= led_partial;
                n++;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: no done within 60 cycles", tag);
        end
        x = sb.pop_front();
        check({tag, " latency"}, n, 8 + DC);
        check({tag, " led_exact"}, int'(acc_e), int'(x.le));
        check({tag, " led_partial"}, int'(acc_p), int'(x.lp));
        check({tag, " leds_off_in_done"}, int'({led_exact, led_partial}), 0);
        check({tag, " exact_count"}, int'(exact_count), int'(x.ec));
        check({tag, " partial_count"}, int'(partial_count), int'(x.pc));
        check({tag, " all_match"}, int'(all_match), int'(x.ec == 3'd4));
    endtask

    vec_t vecs[8];

    initial begin
        int         dones;
        int         busys;
        logic [11:0] rm;
        logic [11:0] rb;
        vecs[0] = '{12'o1234, 12'o1234, '{4'b1111, 4'b0000, 3'd4, 3'd0}};
        vecs[1] = '{12'o1234, 12'o4321, '{4'b0000, 4'b1111, 3'd0, 3'd4}};
        vecs[2] = '{12'o1122, 12'o1211, '{4'b1000, 4'b0110, 3'd1, 3'd2}};
        vecs[3] = '{12'o1200, 12'o1002, '{4'b1000, 4'b0001, 3'd1, 3'd1}};
        vecs[4] = '{12'o0000, 12'o0000, '{4'b0000, 4'b0000, 3'd0, 3'd0}};
        vecs[5] = '{12'o7777, 12'o7777, '{4'b1111, 4'b0000, 3'd4, 3'd0}};
        vecs[6] = '{12'o1000, 12'o0111, '{4'b0000, 4'b0100, 3'd0, 3'd1}};
        vecs[7] = '{12'o1234, 12'o5555, '{4'b0000, 4'b0000, 3'd0, 3'd0}};

        reset = 1'b0;
        LED_Proc = 1'b0;
        cm = '0;
        cb = '0;
        #1;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset leds", int'({led_exact, led_partial}), 0);
        check("reset counts", int'({exact_count, partial_count, all_match}), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_case(vecs[i].m, vecs[i].b, vecs[i].e, $sformatf("vec%0d", i));

        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 4; k++) begin
                rm[3*k +: 3] = 3'($urandom_range(0, 3));
                rb[3*k +: 3] = 3'($urandom_range(0, 3));
            end
            run_case(rm, rb, model(rm, rb), $sformatf("rnd%0d", r));
        end

        // Held request with a second rising edge during SHOW.
        @(negedge clk);
        cm = 12'o1234;
        cb = 12'o1243;
        LED_Proc = 1'b1;
        dones = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) dones++;
            if (k == 10) LED_Proc = 1'b0;
            if (k == 11) LED_Proc = 1'b1;
            if (k == 20) LED_Proc = 1'b0;
        end
        check("held done_pulses", dones, 1);
        check("held exact_count", int'(exact_count), 2);
        check("held partial_count", int'(partial_count), 2);
        check("held idle_busy", int'(busy), 0);

        // Reset during PARTIAL with the request level held high.
        @(negedge clk);
        cm = 12'o1234;
        cb = 12'o1234;
        LED_Proc = 1'b1;
        repeat (6) @(negedge clk);
        check("pre_reset exact_count", int'(exact_count), 4);
        check("pre_reset busy", int'(busy), 1);
        #2 reset = 1'b0;
        #1;
        check("midrun_reset busy", int'(busy), 0);
        check("midrun_reset counts",
              int'({exact_count, partial_count, all_match}), 0);
        @(negedge clk);
        reset = 1'b1;
        busys = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || done) busys++;
        end
        check("held_after_reset no_run", busys, 0);
        LED_Proc = 1'b0;
        run_case(12'o3311, 12'o1133, model(12'o3311, 12'o1133), "rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
